fetch_ctrl: RTL and testbench



---
 rtl/fetch_pkg.sv | 24 ++
 rtl/fetch_if.sv | 24 ++
 rtl/fetch_wait_cnt.sv | 26 ++
 rtl/fetch_ctrl.sv | 121 ++++++++++++
 tb/tb_fetch_ctrl.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch sequencer: PC mux selects, FSM states,
// exception cause codes.
package fetch_pkg;

    typedef enum logic [1:0] {
        SEL_INIT   = 2'b00,
        SEL_SEQ    = 2'b01,
        SEL_BRANCH = 2'b10,
        SEL_VEC    = 2'b11
    } sel_pc_t;

    typedef enum logic [1:0] {
        BOOT,
        WAIT,
        FETCH,
        HALT
    } state_t;

    typedef enum logic [1:0] {
        EX_NONE = 2'b00,
        EX_EXT  = 2'b01
    } ex_code_t;

endpackage

// File: rtl/fetch_if.sv
// Control bundle between the fetch sequencer (master) and the fetch datapath /
// decode side (slave).
interface fetch_if;
    logic       stall;
    logic       branch_taken;
    logic       halt_req;
    logic       resume;
    logic       exc_req;
    logic [1:0] sel_pc;
    logic       enable_pc;
    logic       inst_valid;
    logic       flush;
    logic [1:0] ex_vector;

    modport master (
        input  stall, branch_taken, halt_req, resume, exc_req,
        output sel_pc, enable_pc, inst_valid, flush, ex_vector
    );

    modport slave (
        output stall, branch_taken, halt_req, resume, exc_req,
        input  sel_pc, enable_pc, inst_valid, flush, ex_vector
    );
endinterface

// File: rtl/fetch_wait_cnt.sv
// Loadable 4-bit down-counter that times the instruction-memory read latency.
// Stops at zero; cnt_one flags the last wait cycle.
module fetch_wait_cnt (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       cnt_one
);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign cnt_one = (cnt == 4'd1);

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: drives PC mux/enable, hides memory latency, flags
// valid/flush to decode. FETCH_EXC_EN adds the exception redirect to vector 0.
//
//   state | meaning
//   BOOT  | load initial PC (also the reset state)
//   WAIT  | memory latency countdown after a PC load
//   FETCH | instruction valid; advance, stall, branch or halt
//   HALT  | fetch stopped; PC held until resume
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int MEM_LAT = 0
) (
    input  logic     clk,
    input  logic     reset,
    fetch_if.master  bus
);

    localparam logic [3:0] LAT       = 4'(MEM_LAT);
    localparam state_t     RELOAD_ST = (MEM_LAT == 0) ? FETCH : WAIT;

    state_t state, state_nx;
    logic   cnt_load, cnt_dec, cnt_one;
    logic   exc_take, exc_hit;

    fetch_wait_cnt u_wait_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (LAT),
        .dec      (cnt_dec),
        .cnt_one  (cnt_one)
    );

`ifdef FETCH_EXC_EN
    ex_code_t ex_q;

    assign exc_take = bus.exc_req && (state != BOOT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) ex_q <= EX_NONE;
        else        ex_q <= exc_hit ? EX_EXT : EX_NONE;
    end

    assign bus.ex_vector = ex_q;
`else
    logic unused_exc;

    assign exc_take      = 1'b0;
    assign unused_exc    = bus.exc_req ^ exc_hit;
    assign bus.ex_vector = EX_NONE;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= BOOT;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx       = state;
        bus.sel_pc     = SEL_SEQ;
        bus.enable_pc  = 1'b0;
        bus.inst_valid = 1'b0;
        bus.flush      = 1'b0;
        cnt_load       = 1'b0;
        cnt_dec        = 1'b0;
        exc_hit        = 1'b0;

        // exception and branch redirects share the same shape in every active state
        if (state != BOOT && exc_take) begin
            bus.sel_pc    = SEL_VEC;
            bus.enable_pc = 1'b1;
            bus.flush     = 1'b1;
            exc_hit       = 1'b1;
            cnt_load      = 1'b1;
            state_nx      = RELOAD_ST;
        end else if (state != BOOT && bus.branch_taken) begin
            bus.sel_pc    = SEL_BRANCH;
            bus.enable_pc = 1'b1;
            bus.flush     = 1'b1;
            if (state != HALT) begin
                cnt_load = 1'b1;
                state_nx = RELOAD_ST;
            end
        end else begin
            case (state)
                BOOT: begin
                    bus.sel_pc    = SEL_INIT;
                    bus.enable_pc = 1'b1;
                    cnt_load      = 1'b1;
                    state_nx      = RELOAD_ST;
                end
                WAIT: begin
                    cnt_dec = 1'b1;
                    if (cnt_one) state_nx = FETCH;
                end
                FETCH: begin
                    if (bus.halt_req) begin
                        state_nx = HALT;
                    end else if (bus.stall) begin
                        bus.inst_valid = 1'b1;
                    end else begin
                        bus.inst_valid = 1'b1;
                        bus.enable_pc  = 1'b1;
                        cnt_load       = 1'b1;
                        state_nx       = RELOAD_ST;
                    end
                end
                HALT: begin
                    // PC is untouched, so the halted instruction is refetched
                    if (bus.resume) begin
                        cnt_load = 1'b1;
                        state_nx = RELOAD_ST;
                    end
                end
                default: state_nx = BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: four instances (MEM_LAT 0..3) share stimulus;
// each scenario selects one instance and checks it against hand-computed cycles.
module tb_fetch_ctrl;

    typedef struct {
        logic [6:0] outs;
        int         pc;
        int         sc;
        int         cy;
    } exp_t;

    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] ST   = 5'b10000;
    localparam logic [4:0] BR   = 5'b01000;
    localparam logic [4:0] HL   = 5'b00100;
    localparam logic [4:0] RS   = 5'b00010;
    localparam logic [4:0] EX   = 5'b00001;

    logic        clk;
    logic        reset;
    logic        stall, branch_taken, halt_req, resume, exc_req;
    logic [15:0] branch_pc;
    logic [15:0] pc;
    logic [6:0]  outs_a [4];
    int          act;
    int          sc, cy;
    int          tests, failed;
    exp_t        q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar i = 0; i < 4; i++) begin : g
        fetch_if bus ();
        fetch_ctrl #(.MEM_LAT(i)) u_dut (
            .clk   (clk),
            .reset (reset),
            .bus   (bus)
        );
        assign bus.stall        = stall;
        assign bus.branch_taken = branch_taken;
        assign bus.halt_req     = halt_req;
        assign bus.resume       = resume;
        assign bus.exc_req      = exc_req;
        assign outs_a[i] = {bus.sel_pc, bus.enable_pc, bus.inst_valid, bus.flush, bus.ex_vector};
    end

    // PC register of the datapath, steered by the selected controller
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc <= 16'h0100;
        end else if (outs_a[act][4]) begin
            case (outs_a[act][6:5])
                2'b00:   pc <= 16'h0100;
                2'b01:   pc <= pc + 16'd1;
                2'b10:   pc <= branch_pc;
                default: pc <= 16'h0000;
            endcase
        end
    end

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            tests++;
            if (outs_a[act] !== e.outs) begin
                failed++;
                $display("FAIL outs sc%0d cy%0d got %b want %b", e.sc, e.cy, outs_a[act], e.outs);
            end
            if (e.pc >= 0) begin
                tests++;
                if (int'(pc) != e.pc) begin
                    failed++;
                    $display("FAIL pc sc%0d cy%0d got %h want %h", e.sc, e.cy, pc, e.pc[15:0]);
                end
            end
        end
    end

    function automatic logic [6:0] E(logic [1:0] s, logic en, logic iv, logic fl, logic [1:0] ex);
        return {s, en, iv, fl, ex};
    endfunction

    task automatic push(input logic [6:0] o, input int p);
        exp_t e;
        e.outs = o;
        e.pc   = p;
        e.sc   = sc;
        e.cy   = cy;
        q.push_back(e);
        cy++;
    endtask

    task automatic cyc(input logic [4:0] in, input logic [6:0] o, input int p);
        {stall, branch_taken, halt_req, resume, exc_req} = in;
        push(o, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int a, input int s);
        {stall, branch_taken, halt_req, resume, exc_req} = NONE;
        sc        = s;
        cy        = 0;
        reset     = 1'b0;
        act       = a;
        branch_pc = 16'h0200;
        push(E(2'b00, 1, 0, 0, 2'b00), 'h100);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        tests = 0;
        failed = 0;
        act = 0;
        sc = 0;
        cy = 0;
        reset = 1'b0;
        branch_pc = 16'h0200;
        {stall, branch_taken, halt_req, resume, exc_req} = NONE;
        @(posedge clk);
        #1;

        // boot, MEM_LAT=2
        do_reset(2, 1);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h101);

        // stall, MEM_LAT=0
        do_reset(0, 2);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h101);
        cyc(ST,   E(2'b01, 0, 1, 0, 2'b00), 'h102);
        cyc(ST,   E(2'b01, 0, 1, 0, 2'b00), 'h102);
        cyc(ST,   E(2'b01, 0, 1, 0, 2'b00), 'h102);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h102);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h103);

        // branch during WAIT, MEM_LAT=3
        do_reset(3, 3);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(BR,   E(2'b10, 1, 0, 1, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h200);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h200);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h200);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h200);

        // priority branch > halt > stall, then branch while halted, MEM_LAT=0
        do_reset(0, 4);
        cyc(NONE,         E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(BR | HL | ST, E(2'b10, 1, 0, 1, 2'b00), 'h100);
        cyc(HL | ST,      E(2'b01, 0, 0, 0, 2'b00), 'h200);
        cyc(NONE,         E(2'b01, 0, 0, 0, 2'b00), 'h200);
        branch_pc = 16'h0300;
        cyc(BR,           E(2'b10, 1, 0, 1, 2'b00), 'h200);
        cyc(RS,           E(2'b01, 0, 0, 0, 2'b00), 'h300);
        cyc(NONE,         E(2'b01, 1, 1, 0, 2'b00), 'h300);

        // halt/resume, MEM_LAT=1
        do_reset(1, 5);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(HL,   E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(RS,   E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 1, 1, 0, 2'b00), 'h100);

        // exception with branch, MEM_LAT=0; exc_req ignored in BOOT
        do_reset(0, 6);
        cyc(EX,      E(2'b00, 1, 0, 0, 2'b00), 'h100);
`ifdef FETCH_EXC_EN
        cyc(EX | BR, E(2'b11, 1, 0, 1, 2'b00), 'h100);
        cyc(NONE,    E(2'b01, 1, 1, 0, 2'b01), 'h000);
        cyc(NONE,    E(2'b01, 1, 1, 0, 2'b00), 'h001);
`else
        cyc(EX | BR, E(2'b10, 1, 0, 1, 2'b00), 'h100);
        cyc(EX,      E(2'b01, 1, 1, 0, 2'b00), 'h200);
        cyc(NONE,    E(2'b01, 1, 1, 0, 2'b00), 'h201);
`endif

        // reset asserted mid-WAIT, MEM_LAT=3
        do_reset(3, 7);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);
        do_reset(3, 8);
        cyc(NONE, E(2'b00, 1, 0, 0, 2'b00), 'h100);
        cyc(NONE, E(2'b01, 0, 0, 0, 2'b00), 'h100);

        @(posedge clk);
        #1;
        tests++;
        if (q.size() != 0) begin
            failed++;
            $display("FAIL drain got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
